jt49_player: RTL

Register-dump player that sits directly upstream of the jt49 PSG and drives its write port (`addr`/`cs_n`/`wr_n`/`din`). It accepts 14-byte register frames (regs 0..13) over a valid/ready byte stream into a double buffer. At each frame tick it replays the buffered frame into the PSG as a sequence of single writes. It runs on the same `clk`/`clk_en` as the PSG, so the PSG write-edge logic and envelope-restart logic see clean, separated write pulses.

---
 rtl/jt49_player_pkg.sv | 21 ++
 rtl/jt49_frame_buf.sv | 89 ++++++++
 rtl/jt49_player.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/jt49_player_pkg.sv
// jt49_player_pkg
//   Shared constants and the sequencer state type for the jt49 register-dump
//   player (jt49_player and jt49_frame_buf).
package jt49_player_pkg;

    // Registers per PSG frame (R0..R13)
    localparam int unsigned NREGS    = 14;
    localparam logic [3:0]  LAST_REG = 4'(NREGS - 1);

    // R13 value meaning "leave the envelope alone": R13 is not written, so the
    // PSG does not restart its envelope
    localparam logic [7:0]  SKIP_R13 = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WR_LO,
        WR_HI
    } state_t;

endpackage

// File: rtl/jt49_frame_buf.sv
// jt49_frame_buf
//   Two-bank frame store (2 x 14 bytes) that sits between the byte-stream
//   loader and the playback sequencer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_load_valid        load byte valid
//   i_load_data[7:0]    load byte, sent in register order R0..R13
//   o_load_ready        fill bank can accept a byte
//   i_take              sequencer claims the next full bank for playback
//   i_release_bank      sequencer is done with bank i_play_sel
//   i_play_sel          bank currently being played
//   i_rd_bank, i_rd_idx read address (bank, register)
//   o_rd_data[7:0]      byte at (i_rd_bank, i_rd_idx)
//   o_rd_r13[7:0]       R13 of bank i_rd_bank (used for the envelope skip)
//   o_next_sel          bank the next playback will take
//   o_next_full         that bank holds a complete frame
module jt49_frame_buf
    import jt49_player_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    output logic       o_load_ready,
    input  logic       i_take,
    input  logic       i_release_bank,
    input  logic       i_play_sel,
    input  logic       i_rd_bank,
    input  logic [3:0] i_rd_idx,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_rd_r13,
    output logic       o_next_sel,
    output logic       o_next_full
);

    logic [7:0] r_bank [2][NREGS];
    logic [1:0] r_full;
    logic       r_fill_sel;
    logic       r_next_sel;
    logic [3:0] r_idx;
    logic       w_load;

    // The fill bank advances as soon as a bank completes and the play side
    // keeps its own pointer, so up to two frames can be queued ahead of
    // playback and are replayed in load order.
    assign o_load_ready = ~r_full[r_fill_sel];
    assign w_load       = i_load_valid & o_load_ready;

    assign o_rd_data    = r_bank[i_rd_bank][i_rd_idx];
    assign o_rd_r13     = r_bank[i_rd_bank][LAST_REG];
    assign o_next_sel   = r_next_sel;
    assign o_next_full  = r_full[r_next_sel];

    // Storage needs no reset: a bank is only read once its full flag is set
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_bank[r_fill_sel][r_idx] <= i_load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_fill_sel <= 1'b0;
            r_next_sel <= 1'b0;
            r_idx      <= '0;
        end else begin
            // The bank being played is full, so a load can never target the
            // bank being released in the same cycle.
            if (i_release_bank) begin
                r_full[i_play_sel] <= 1'b0;
            end
            if (i_take) begin
                r_next_sel <= ~r_next_sel;
            end
            if (w_load) begin
                if (r_idx == LAST_REG) begin
                    r_full[r_fill_sel] <= 1'b1;
                    r_fill_sel         <= ~r_fill_sel;
                    r_idx              <= '0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/jt49_player.sv
// jt49_player
//   Register-dump player placed directly upstream of the jt49 PSG. Frames of
//   14 register bytes are loaded over a valid/ready stream into a double
//   buffer; every FRAME_DIV clk_en pulses the next buffered frame is replayed
//   into the PSG write port as separated single-register write pulses.
//
// Parameters
//   FRAME_DIV   clk_en pulses per frame (>= 32)
//   DIVW        frame tick counter width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clk_en                PSG clock enable; qualifies tick counter and FSM
//   start, stop           single-cycle playback control pulses
//   load_valid/load_data  frame byte stream (R0..R13 order)
//   load_ready            fill bank can accept a byte
//   psg_addr/psg_dout     PSG register address / data (registered)
//   psg_cs_n/psg_wr_n     PSG chip select / write strobe (registered)
//   busy                  sequencer not idle
//   underrun              sticky: tick without a full frame, or tick mid-sequence
//   frame_cnt             completed frames, wrapping
module jt49_player
    import jt49_player_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 60000,
    parameter int unsigned DIVW      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic        stop,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic [3:0]  psg_addr,
    output logic [7:0]  psg_dout,
    output logic        psg_cs_n,
    output logic        psg_wr_n,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    state_t            r_state;
    logic [DIVW-1:0]   r_cnt;
    logic              r_play_sel;
    logic [3:0]        r_reg_i;
    logic              r_start_pend;
    logic              r_stop_pend;
    logic              r_cs_n;
    logic [3:0]        r_addr;
    logic [7:0]        r_dout;
    logic              r_underrun;
    logic [15:0]       r_frame_cnt;

    logic              w_tick;
    logic              w_start;
    logic              w_stop;
    logic              w_take;
    logic              w_last;
    logic              w_release;
    logic              w_rd_bank;
    logic [3:0]        w_rd_idx;
    logic [7:0]        w_rd_data;
    logic [7:0]        w_rd_r13;
    logic              w_next_sel;
    logic              w_next_full;

    jt49_frame_buf u_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load_valid   (load_valid),
        .i_load_data    (load_data),
        .o_load_ready   (load_ready),
        .i_take         (w_take),
        .i_release_bank (w_release),
        .i_play_sel     (r_play_sel),
        .i_rd_bank      (w_rd_bank),
        .i_rd_idx       (w_rd_idx),
        .o_rd_data      (w_rd_data),
        .o_rd_r13       (w_rd_r13),
        .o_next_sel     (w_next_sel),
        .o_next_full    (w_next_full)
    );

    // start/stop are single clk pulses that may fall between clk_en cycles,
    // so they are held as pending until the FSM can act on them.
    assign w_start = start | r_start_pend;
    assign w_stop  = stop  | r_stop_pend;

    assign w_tick  = clk_en && (r_state != IDLE) &&
                     (r_cnt == DIVW'(FRAME_DIV - 1));

    // The PSG outputs are loaded on the same edge that enters WR_LO, so the
    // read address looks one register ahead: the bank about to be claimed
    // while in WAIT, the next register while in WR_HI.
    assign w_rd_bank = (r_state == WAIT)  ? w_next_sel : r_play_sel;
    assign w_rd_idx  = (r_state == WR_HI) ? (r_reg_i + 4'd1) : 4'd0;

    assign w_last    = (r_reg_i == LAST_REG) ||
                       ((r_reg_i == LAST_REG - 4'd1) && (w_rd_r13 == SKIP_R13));

    assign w_take    = clk_en && (r_state == WAIT) && !w_stop && w_tick && w_next_full;
    assign w_release = clk_en && (r_state == WR_HI) && (w_stop || w_last);

    assign psg_cs_n  = r_cs_n;
    assign psg_wr_n  = r_cs_n;
    assign psg_addr  = r_addr;
    assign psg_dout  = r_dout;
    assign busy      = (r_state != IDLE);
    assign underrun  = r_underrun;
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_play_sel   <= 1'b0;
            r_reg_i      <= '0;
            r_start_pend <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_cs_n       <= 1'b1;
            r_addr       <= '0;
            r_dout       <= '0;
            r_underrun   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            // Pending control pulses; start is only meaningful in IDLE, stop
            // only outside it. A simultaneous stop cancels a start in IDLE.
            if (r_state == IDLE) begin
                r_stop_pend <= 1'b0;
                if (stop) begin
                    r_start_pend <= 1'b0;
                end else if (start) begin
                    r_start_pend <= 1'b1;
                end
            end else begin
                r_start_pend <= 1'b0;
                if (stop) begin
                    r_stop_pend <= 1'b1;
                end
            end

            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (clk_en) begin
                r_cnt <= w_tick ? '0 : (r_cnt + DIVW'(1));
            end

            if (clk_en) begin
                r_cs_n <= 1'b1;
                case (r_state)
                    IDLE: begin
                        if (w_start && !stop) begin
                            r_state      <= WAIT;
                            r_underrun   <= 1'b0;
                            r_start_pend <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (w_stop) begin
                            r_state     <= IDLE;
                            r_stop_pend <= 1'b0;
                        end else if (w_take) begin
                            r_play_sel <= w_next_sel;
                            r_reg_i    <= '0;
                            r_state    <= WR_LO;
                            r_cs_n     <= 1'b0;
                            r_addr     <= '0;
                            r_dout     <= w_rd_data;
                        end else if (w_tick) begin
                            r_underrun <= 1'b1;
                        end
                    end
                    WR_LO: begin
                        if (w_tick) begin
                            r_underrun <= 1'b1;
                        end
                        r_state <= WR_HI;
                    end
                    WR_HI: begin
                        if (w_tick) begin
                            r_underrun <= 1'b1;
                        end
                        // A stop discards the partially played frame, even
                        // if this was its final register.
                        if (w_stop) begin
                            r_state     <= IDLE;
                            r_stop_pend <= 1'b0;
                        end else if (w_last) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_state     <= WAIT;
                        end else begin
                            r_reg_i <= r_reg_i + 4'd1;
                            r_state <= WR_LO;
                            r_cs_n  <= 1'b0;
                            r_addr  <= r_reg_i + 4'd1;
                            r_dout  <= w_rd_data;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
